// File: rtl/pe_dot_pkg.sv
// Shared types and FP32 constants for the pe_dot_seq sequencer.
package pe_dot_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } st_t;

    localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP32_ONE  = 32'h3F80_0000;

endpackage

// File: rtl/pe_dot_wdog.sv
// WAIT-state watchdog: cleared on each issue, counts WAIT cycles, flags the LIMIT-th one.
module pe_dot_wdog
    import pe_dot_pkg::*;
#(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          at_limit;

    assign at_limit  = (cnt_q == CW'(LIMIT - 1));
    assign expired_o = en_i && at_limit;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !at_limit) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pe_dot_seq.sv
// Dot-product sequencer feeding one FP32 PE operation at a time and recirculating its psum.
// Optional watchdog abort enabled by defining PE_DOT_SEQ_TIMEOUT_EN.
module pe_dot_seq
    import pe_dot_pkg::*;
#(
    parameter int LEN_W       = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [31:0]      cmd_bias,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [31:0]      a_data,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [31:0]      b_data,
    output logic             pe_in_valid,
    output logic [31:0]      pe_a_bits,
    output logic [31:0]      pe_b_bits,
    output logic [31:0]      pe_psum_in,
    input  logic             pe_out_valid,
    input  logic [31:0]      pe_psum_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic             res_err
);

    st_t              state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] cnt_inc;
    logic [31:0]      psum_q, psum_d;
    logic [31:0]      pe_a_q, pe_a_d;
    logic [31:0]      pe_b_q, pe_b_d;
    logic [31:0]      pe_psum_q, pe_psum_d;
    logic             pe_in_valid_q, pe_in_valid_d;
    logic             fire;

    // A pair is consumed only when both streams offer at once.
    assign fire    = (state_q == FETCH) && a_valid && b_valid;
    assign cnt_inc = cnt_q + LEN_W'(1);

    assign cmd_ready   = (state_q == IDLE);
    assign a_ready     = (state_q == FETCH) && b_valid;
    assign b_ready     = (state_q == FETCH) && a_valid;
    assign pe_in_valid = pe_in_valid_q;
    assign pe_a_bits   = pe_a_q;
    assign pe_b_bits   = pe_b_q;
    assign pe_psum_in  = pe_psum_q;
    assign res_valid   = (state_q == DONE);
    assign res_data    = psum_q;

`ifdef PE_DOT_SEQ_TIMEOUT_EN
    logic res_err_q, res_err_d;
    logic wdog_expired;

    pe_dot_wdog #(
        .LIMIT(TIMEOUT_CYC)
    ) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (fire),
        .en_i     (state_q == WAIT),
        .expired_o(wdog_expired)
    );

    assign res_err = res_err_q;
`else
    assign res_err = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        cnt_d         = cnt_q;
        psum_d        = psum_q;
        pe_a_d        = pe_a_q;
        pe_b_d        = pe_b_q;
        pe_psum_d     = pe_psum_q;
        pe_in_valid_d = 1'b0;
`ifdef PE_DOT_SEQ_TIMEOUT_EN
        res_err_d     = res_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    len_d   = cmd_len;
                    psum_d  = cmd_bias;
                    cnt_d   = '0;
                    state_d = (cmd_len == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (fire) begin
                    pe_a_d        = a_data;
                    pe_b_d        = b_data;
                    pe_psum_d     = psum_q;
                    pe_in_valid_d = 1'b1;
                    state_d       = WAIT;
                end
            end
            WAIT: begin
                // A late result in the same cycle as expiry still counts.
                if (pe_out_valid) begin
                    psum_d  = pe_psum_out;
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == len_q) ? DONE : FETCH;
                end
`ifdef PE_DOT_SEQ_TIMEOUT_EN
                else if (wdog_expired) begin
                    res_err_d = 1'b1;
                    state_d   = DONE;
                end
`endif
            end
            DONE: begin
                if (res_ready) begin
`ifdef PE_DOT_SEQ_TIMEOUT_EN
                    res_err_d = 1'b0;
`endif
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            len_q         <= '0;
            cnt_q         <= '0;
            psum_q        <= FP32_ZERO;
            pe_a_q        <= FP32_ZERO;
            pe_b_q        <= FP32_ZERO;
            pe_psum_q     <= FP32_ZERO;
            pe_in_valid_q <= 1'b0;
`ifdef PE_DOT_SEQ_TIMEOUT_EN
            res_err_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            cnt_q         <= cnt_d;
            psum_q        <= psum_d;
            pe_a_q        <= pe_a_d;
            pe_b_q        <= pe_b_d;
            pe_psum_q     <= pe_psum_d;
            pe_in_valid_q <= pe_in_valid_d;
`ifdef PE_DOT_SEQ_TIMEOUT_EN
            res_err_q     <= res_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_pe_dot_seq.sv
// Bench for pe_dot_seq: behavioural FP32 PE plus a real-arithmetic dot-product reference.
module tb_pe_dot_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_len = '0;
    logic [31:0] cmd_bias = '0;
    logic        a_valid = 1'b0, a_ready;
    logic [31:0] a_data = '0;
    logic        b_valid = 1'b0, b_ready;
    logic [31:0] b_data = '0;
    logic        pe_in_valid;
    logic [31:0] pe_a_bits, pe_b_bits, pe_psum_in;
    logic        pe_out_valid = 1'b0;
    logic [31:0] pe_psum_out = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic        res_err;

    pe_dot_seq #(.LEN_W(8), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len), .cmd_bias(cmd_bias),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
        .pe_in_valid(pe_in_valid), .pe_a_bits(pe_a_bits), .pe_b_bits(pe_b_bits),
        .pe_psum_in(pe_psum_in), .pe_out_valid(pe_out_valid), .pe_psum_out(pe_psum_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // FP32 <-> real through the double-precision bit layout (normals and zero only).
    function automatic real fp2r(input logic [31:0] f);
        logic [63:0] d;
        int          e;
        if (f[30:23] == 8'd0) return 0.0;
        e = int'(f[30:23]) - 127 + 1023;
        d = {f[31], e[10:0], f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2fp(input real r);
        logic [63:0] d;
        int          e;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        e = int'(d[62:52]) - 1023 + 127;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // Behavioural PE: fixed latency, serves at most pe_limit operations since reset.
    int          pe_lat = 2;
    int          pe_limit = 1000000;
    int          pe_left = 0, pe_served = 0, n_overlap = 0;
    bit          pe_busy = 1'b0;
    logic [31:0] pe_res = '0;

    always @(posedge clk) begin
        pe_out_valid <= 1'b0;
        if (rst) begin
            pe_busy   <= 1'b0;
            pe_served <= 0;
        end else begin
            if (pe_busy) begin
                if (pe_left <= 1) begin
                    pe_busy      <= 1'b0;
                    pe_out_valid <= 1'b1;
                    pe_psum_out  <= pe_res;
                end else begin
                    pe_left <= pe_left - 1;
                end
            end
            if (pe_in_valid) begin
                if (pe_busy) n_overlap <= n_overlap + 1;
                if (pe_served < pe_limit) begin
                    pe_busy   <= 1'b1;
                    pe_left   <= pe_lat;
                    pe_res    <= r2fp(fp2r(pe_psum_in) + fp2r(pe_a_bits) * fp2r(pe_b_bits));
                    pe_served <= pe_served + 1;
                end
            end
        end
    end

    // Protocol monitor: cycle stamps of handshakes and pulse counters.
    int cyc = 0, n_issue = 0, n_dbl = 0, n_fie = 0;
    int last_fire = -10, last_issue = 0, last_out = 0, last_rise = 0, last_acc = 0;
    bit prev_in = 1'b0, prev_res = 1'b0;

    always @(posedge clk) begin
        if (pe_in_valid) begin
            n_issue    <= n_issue + 1;
            last_issue <= cyc;
            if (prev_in) n_dbl <= n_dbl + 1;
            if (last_fire != cyc - 1) n_fie <= n_fie + 1;
        end
        if (a_valid && a_ready) last_fire <= cyc;
        if (pe_out_valid) last_out <= cyc;
        if (res_valid && !prev_res) last_rise <= cyc;
        if (cmd_valid && cmd_ready) last_acc <= cyc;
        prev_in  <= pe_in_valid;
        prev_res <= res_valid;
        cyc      <= cyc + 1;
    end

    logic [31:0] a_q[$];
    logic [31:0] b_q[$];
    bit          saw_rdy;
    int          join_err;

    task automatic chk_rst(input string tag);
        chk({tag, "_ctl"}, {27'd0, pe_in_valid, res_valid, res_err, a_ready, b_ready}, 32'd0);
        chk({tag, "_pe_a"}, pe_a_bits, 32'd0);
        chk({tag, "_pe_b"}, pe_b_bits, 32'd0);
        chk({tag, "_pe_psum"}, pe_psum_in, 32'd0);
        chk({tag, "_res_data"}, res_data, 32'd0);
        chk({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    endtask

    // Runs one command; rst_at>0 pulses reset while the rst_at-th operation is in WAIT.
    task automatic run_cmd(input int len, input logic [31:0] bias, input int hold,
                           input int bound, input int rst_at,
                           output bit done, output logic [31:0] data, output logic err);
        int  ai, bi, base;
        bit  af, bf;
        done = 1'b0; data = '0; err = 1'b0; saw_rdy = 1'b0; join_err = 0;
        ai = 0; bi = 0; base = n_issue;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_len = len[7:0]; cmd_bias = bias;
        chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        for (int c = 0; c < bound; c++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (res_valid) begin
                done = 1'b1;
                break;
            end
            if (rst_at > 0 && pe_in_valid && (n_issue - base) == rst_at - 1) begin
                a_valid = 1'b0; b_valid = 1'b0; rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                chk_rst("mid_wait_rst");
                return;
            end
            a_valid = (ai < len) && ($urandom_range(0, 3) != 0);
            a_data  = (ai < len) ? a_q[ai] : $urandom;
            b_valid = (bi < len) && ($urandom_range(0, 3) != 0);
            b_data  = (bi < len) ? b_q[bi] : $urandom;
            #1;
            if (a_ready || b_ready) saw_rdy = 1'b1;
            af = a_valid && a_ready;
            bf = b_valid && b_ready;
            if (af != bf) join_err++;
            @(posedge clk);
            if (af) ai++;
            if (bf) bi++;
        end
        a_valid = 1'b0; b_valid = 1'b0;
        chk("joint_consume", join_err, 0);
        if (!done) return;
        data = res_data;
        err  = res_err;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_res_valid", {31'd0, res_valid}, 32'd1);
            chk("hold_res_data", res_data, data);
            chk("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        end
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        chk("post_hs_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("post_hs_res_err", {31'd0, res_err}, 32'd0);
    endtask

    task automatic load_case1();
        a_q = '{32'h3F800000, 32'h40000000, 32'h40400000};
        b_q = '{32'h40800000, 32'h40A00000, 32'h40C00000};
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        bit          done;
        logic [31:0] data;
        logic        err;
        int          base, dbl0, fie0, ovl0, ok;
        real         exp_r;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_rst("reset_hold");
        rst = 1'b0;
        @(negedge clk);
        chk_rst("after_reset");

        // Case 1: basic dot product.
        load_case1();
        base = n_issue; dbl0 = n_dbl;
        run_cmd(3, 32'h0, 0, 200, 0, done, data, err);
        chk("c1_done", {31'd0, done}, 32'd1);
        chk("c1_data", data, 32'h42000000);
        chk("c1_issues", n_issue - base, 3);
        chk("c1_single_cycle", n_dbl - dbl0, 0);
        chk("c1_res_after_out", last_rise - last_out, 1);

        // Case 2: bias, then zero length.
        run_cmd(3, 32'h3F800000, 1, 200, 0, done, data, err);
        chk("c2_data", data, 32'h42040000);
        base = n_issue;
        run_cmd(0, 32'h40490FDB, 0, 10, 0, done, data, err);
        chk("len0_done", {31'd0, done}, 32'd1);
        chk("len0_data", data, 32'h40490FDB);
        chk("len0_no_ready", {31'd0, saw_rdy}, 32'd0);
        chk("len0_no_issue", n_issue - base, 0);
        ok = ((last_rise - last_acc) >= 1 && (last_rise - last_acc) <= 2) ? 1 : 0;
        chk("len0_latency", ok, 1);

        // Case 3: stream skew.
        base = n_issue;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_len = 8'd1; cmd_bias = 32'h0;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        a_valid = 1'b1; a_data = 32'h40000000; b_valid = 1'b0; b_data = 32'h40400000;
        ok = 1;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (a_ready || pe_in_valid) ok = 0;
            @(negedge clk);
        end
        chk("skew_no_consume", ok, 1);
        b_valid = 1'b1;
        #1;
        chk("skew_fire_ready", {30'd0, a_ready, b_ready}, 32'd3);
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            if (res_valid) done = 1'b1;
            else @(negedge clk);
        end
        chk("skew_data", res_data, 32'h40C00000);
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        chk("skew_one_issue", n_issue - base, 1);

        // Case 4: result backpressure with case-1 vectors.
        run_cmd(3, 32'h0, 5, 200, 0, done, data, err);
        chk("bp_data", data, 32'h42000000);

        // Case 5: reset during the second element's WAIT, then a clean rerun.
        run_cmd(3, 32'h0, 0, 200, 2, done, data, err);
        chk("rst_aborted", {31'd0, done}, 32'd0);
        run_cmd(3, 32'h0, 0, 200, 0, done, data, err);
        chk("rst_rerun_data", data, 32'h42000000);

        // Randomised commands against a real-valued reference.
        for (int t = 0; t < 14; t++) begin
            int len, v;
            logic [31:0] bias;
            len = (t % 7 == 6) ? 0 : int'($urandom_range(1, 8));
            v = int'($urandom_range(0, 16)) - 8;
            bias = r2fp(real'(v));
            exp_r = real'(v);
            a_q.delete(); b_q.delete();
            for (int k = 0; k < len; k++) begin
                int x, y;
                x = int'($urandom_range(0, 16)) - 8;
                y = int'($urandom_range(0, 16)) - 8;
                a_q.push_back(r2fp(real'(x)));
                b_q.push_back(r2fp(real'(y)));
                exp_r = exp_r + real'(x) * real'(y);
            end
            pe_lat = int'($urandom_range(1, 5));
            base = n_issue; dbl0 = n_dbl; fie0 = n_fie; ovl0 = n_overlap;
            run_cmd(len, bias, int'($urandom_range(0, 2)), 600, 0, done, data, err);
            chk($sformatf("rnd%0d_data", t), data, r2fp(exp_r));
            chk($sformatf("rnd%0d_err", t), {31'd0, err}, 32'd0);
            chk($sformatf("rnd%0d_issues", t), n_issue - base, len);
            chk($sformatf("rnd%0d_proto", t), (n_dbl - dbl0) + (n_fie - fie0) + (n_overlap - ovl0), 0);
            if (len > 0) chk($sformatf("rnd%0d_res_lat", t), last_rise - last_out, 1);
        end

        // Case 6: PE stops answering after element 1.
        load_case1();
        pe_lat = 2;
        do_reset();
        pe_limit = 1;
`ifdef PE_DOT_SEQ_TIMEOUT_EN
        run_cmd(3, 32'h0, 0, 200, 0, done, data, err);
        chk("wdog_done", {31'd0, done}, 32'd1);
        chk("wdog_err", {31'd0, err}, 32'd1);
        chk("wdog_data", data, 32'h40800000);
        chk("wdog_wait_cycles", last_rise - last_issue, 16);
`else
        run_cmd(3, 32'h0, 0, 100, 0, done, data, err);
        chk("no_wdog_still_waiting", {31'd0, done}, 32'd0);
        chk("no_wdog_res_err", {31'd0, res_err}, 32'd0);
`endif
        pe_limit = 1000000;
        do_reset();
        run_cmd(3, 32'h0, 0, 200, 0, done, data, err);
        chk("final_data", data, 32'h42000000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
